uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (uarttx instance inside uart_top) between NUM_REQ byte requesters.
- Round-robin arbitration between requesters; a multi-byte frame locks the grant until its last byte.
- Drives the transmitter's newd/tx_data pair and times the start pulse against the baud tick.
- Watches donetx to acknowledge each byte; a timeout recovers from a lost donetx.

---
 rtl/uart_tx_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// uart_tx_arbiter
// Shares a single UART transmitter between NUM_REQ byte requesters.
// Requesters are served round-robin. A multi-byte frame keeps the grant until
// its last byte. Each byte is started with a tx_newd pulse held long enough to
// span a baud tick. Each byte is acknowledged on the rising edge of the
// transmitter's done level. A timeout recovers when that edge never arrives.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   req       in   [NUM_REQ]   per-requester byte request, held with data until ack
//   req_data  in   [8*NUM_REQ] byte i at [8i+7:8i]
//   req_last  in   [NUM_REQ]   byte closes its frame
//   ack       out  [NUM_REQ]   one-cycle pulse, byte consumed
//   grant     out  [NUM_REQ]   one-hot current owner, 0 when idle
//   tx_newd   out  start strobe to the transmitter
//   tx_data   out  [8] byte to the transmitter
//   tx_done   in   done level from the transmitter
//   busy      out  high whenever the sequencer is not idle
//   err       out  sticky timeout flag, cleared only by rst
module uart_tx_arbiter #(
  parameter int clk_freq       = 1000000,
  parameter int baud_rate      = 9600,
  parameter int NUM_REQ        = 4,
  parameter int HOLD_CYCLES    = clk_freq / baud_rate + 2,
  parameter int TIMEOUT_CYCLES = 16 * HOLD_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_newd,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 err
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [HOLD_W-1:0]  HOLD_END = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_END   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    NEXT = 2'd3
  } state_t;

  state_t            state_r;
  logic [IDX_W-1:0]  rr_ptr_r;
  logic [IDX_W-1:0]  winner_r;
  logic              lock_r;
  logic              last_r;     // req_last of the byte currently in flight
  logic              done_q_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [TO_W-1:0]   to_cnt_r;

  logic              done_rise_s;
  logic              pick_valid_s;
  logic [IDX_W-1:0]  pick_idx_s;
  logic [IDX_W-1:0]  cand_s;
  logic [7:0]        pick_byte_s;
  logic [7:0]        win_byte_s;

  // Next requester index after idx, wrapping NUM_REQ-1 back to 0.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (idx == LAST_IDX) begin
      return {IDX_W{1'b0}};
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

  // Only a fresh rising edge of done acknowledges a byte. A level still high
  // from an earlier transfer does not.
  assign done_rise_s = tx_done & ~done_q_r;

  // Byte presented by the arbitration winner and by the locked owner.
  assign pick_byte_s = req_data[{pick_idx_s, 3'b000} +: 8];
  assign win_byte_s  = req_data[{winner_r, 3'b000} +: 8];

  // Round-robin search: first active request at or above rr_ptr, wrapping.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = {IDX_W{1'b0}};
    cand_s       = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = IDX_W'((int'(rr_ptr_r) + i) % NUM_REQ);
      if (!pick_valid_s && req[cand_s]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = cand_s;
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // History register for done edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q_r <= 1'b0;
    end else begin
      done_q_r <= tx_done;
    end
  end

  // Transfer sequencer: arbitration, start-strobe timing, ack, frame lock, timeouts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      rr_ptr_r   <= {IDX_W{1'b0}};
      winner_r   <= {IDX_W{1'b0}};
      lock_r     <= 1'b0;
      last_r     <= 1'b0;
      hold_cnt_r <= {HOLD_W{1'b0}};
      to_cnt_r   <= {TO_W{1'b0}};
      grant      <= {NUM_REQ{1'b0}};
      ack        <= {NUM_REQ{1'b0}};
      tx_newd    <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      ack <= {NUM_REQ{1'b0}};
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            winner_r   <= pick_idx_s;
            grant      <= ONE_HOT0 << pick_idx_s;
            tx_data    <= pick_byte_s;
            last_r     <= req_last[pick_idx_s];
            tx_newd    <= 1'b1;
            hold_cnt_r <= {HOLD_W{1'b0}};
            busy       <= 1'b1;
            state_r    <= LOAD;
          end else begin
            busy <= 1'b0;
          end
        end

        // tx_newd stays high for HOLD_CYCLES cycles so a baud tick lands inside it.
        LOAD: begin
          if (hold_cnt_r == HOLD_END) begin
            tx_newd  <= 1'b0;
            to_cnt_r <= {TO_W{1'b0}};
            state_r  <= WAIT;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end

        WAIT: begin
          if (done_rise_s) begin
            ack      <= grant;
            to_cnt_r <= {TO_W{1'b0}};
            state_r  <= NEXT;
          end else if (to_cnt_r == TO_END) begin
            // Lost done: give up on this byte and demote the stuck requester.
            err      <= 1'b1;
            lock_r   <= 1'b0;
            grant    <= {NUM_REQ{1'b0}};
            rr_ptr_r <= wrap_inc(winner_r);
            busy     <= 1'b0;
            state_r  <= IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end

        // The ack is visible here. The owner either closes its frame or supplies the next byte.
        NEXT: begin
          if (last_r) begin
            lock_r   <= 1'b0;
            grant    <= {NUM_REQ{1'b0}};
            rr_ptr_r <= wrap_inc(winner_r);
            busy     <= 1'b0;
            state_r  <= IDLE;
          end else if (req[winner_r]) begin
            lock_r     <= 1'b1;
            tx_data    <= win_byte_s;
            last_r     <= req_last[winner_r];
            tx_newd    <= 1'b1;
            hold_cnt_r <= {HOLD_W{1'b0}};
            state_r    <= LOAD;
          end else if (lock_r && (to_cnt_r == TO_END)) begin
            // Frame abandoned mid-way by its owner.
            err     <= 1'b1;
            lock_r  <= 1'b0;
            grant   <= {NUM_REQ{1'b0}};
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            lock_r   <= 1'b1;
            to_cnt_r <= lock_r ? (to_cnt_r + TO_W'(1)) : {TO_W{1'b0}};
          end
        end

        default: begin
          lock_r  <= 1'b0;
          grant   <= {NUM_REQ{1'b0}};
          tx_newd <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for uart_tx_arbiter.
// A behavioural transmitter stand-in captures each started byte and raises a
// done level some time after the start strobe. Expected service order comes
// from a transaction-level round-robin model over per-requester byte lists.
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int HOLD = 106;
  localparam int TOUT = 1696;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   ack;
  logic [NR-1:0]   grant;
  logic            tx_newd;
  logic [7:0]      tx_data;
  logic            tx_done;
  logic            busy;
  logic            err;

  uart_tx_arbiter #(
    .clk_freq (1000000),
    .baud_rate(9600),
    .NUM_REQ  (NR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_data(req_data),
    .req_last(req_last),
    .ack     (ack),
    .grant   (grant),
    .tx_newd (tx_newd),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .busy    (busy),
    .err     (err)
  );

  int checks = 0;
  int errors = 0;

  // transmitter stand-in controls
  bit         uart_en  = 1'b1;
  int         done_min = 50;
  int         done_max = 150;
  int         done_cd  = 0;
  int         done_hold = 0;
  logic [7:0] cap_q[$];

  // requester byte lists and the expected service order
  logic [7:0] rq_byte [NR][16];
  bit         rq_last [NR][16];
  int         rq_cnt  [NR];
  int         rq_pos  [NR];
  int         exp_idx[$];
  int         exp_byte[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int first_set(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = NR - 1; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  // Transmitter stand-in: measure each start strobe, capture its byte, schedule done.
  initial begin : uart_model
    int len;
    bit stable;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx_newd === 1'b1) begin
        b = tx_data;
        len = 0;
        stable = 1'b1;
        while (tx_newd === 1'b1 && len < 5000) begin
          if (tx_data !== b) stable = 1'b0;
          len++;
          @(negedge clk);
        end
        check_eq("newd_len", 32'(len), 32'(HOLD));
        check_eq("data_stable", 32'(stable), 32'd1);
        cap_q.push_back(b);
        if (uart_en) done_cd = $urandom_range(done_max, done_min);
      end
    end
  end

  // Done level driver: rises when the countdown expires, holds a random length.
  initial begin : done_driver
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done_hold > 0) begin
        done_hold--;
        if (done_hold == 0) tx_done = 1'b0;
      end
      if (done_cd > 0) begin
        done_cd--;
        if (done_cd == 0) begin
          tx_done = 1'b1;
          done_hold = $urandom_range(150, 20);
        end
      end
    end
  end

  task automatic do_reset();
    repeat (160) @(negedge clk);
    rst = 1'b1;
    req = '0;
    req_data = '0;
    req_last = '0;
    done_cd = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cap_q.delete();
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin
      rq_cnt[i] = 0;
      rq_pos[i] = 0;
    end
  endtask

  task automatic add_byte(input int i, input logic [7:0] b, input bit l);
    rq_byte[i][rq_cnt[i]] = b;
    rq_last[i][rq_cnt[i]] = l;
    rq_cnt[i]++;
  endtask

  task automatic apply_reqs();
    for (int i = 0; i < NR; i++) begin
      if (rq_pos[i] < rq_cnt[i]) begin
        req[i] = 1'b1;
        req_data[8*i +: 8] = rq_byte[i][rq_pos[i]];
        req_last[i] = rq_last[i][rq_pos[i]];
      end else begin
        req[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
  endtask

  // Reference: pick the first requester with bytes left from the pointer,
  // send its whole frame, move the pointer one past it.
  task automatic build_expected();
    int pos[NR];
    int p;
    int w;
    int c;
    exp_idx.delete();
    exp_byte.delete();
    for (int i = 0; i < NR; i++) pos[i] = 0;
    p = 0;
    while (1) begin
      w = -1;
      for (int k = 0; k < NR; k++) begin
        c = (p + k) % NR;
        if (w < 0 && pos[c] < rq_cnt[c]) w = c;
      end
      if (w < 0) break;
      do begin
        exp_idx.push_back(w);
        exp_byte.push_back(int'(rq_byte[w][pos[w]]));
        pos[w]++;
      end while (!rq_last[w][pos[w]-1]);
      p = (w + 1) % NR;
    end
  endtask

  task automatic run_scenario(input string tag);
    int n_exp;
    int got;
    int cyc;
    int idx;
    int cb;
    logic [NR-1:0] a;
    build_expected();
    n_exp = exp_idx.size();
    got = 0;
    cyc = 0;
    @(negedge clk);
    apply_reqs();
    while (got < n_exp && cyc < n_exp * 600 + 1000) begin
      @(negedge clk);
      cyc++;
      check_eq({tag, "_grant_onehot"}, 32'($countones(grant) <= 1), 32'd1);
      if (ack != '0) begin
        a = ack;
        idx = first_set(a);
        check_eq({tag, "_ack_onehot"}, 32'($countones(a)), 32'd1);
        check_eq({tag, "_ack_eq_grant"}, 32'(a), 32'(grant));
        check_eq({tag, "_ack_idx"}, 32'(idx), 32'(exp_idx[got]));
        if (cap_q.size() > 0) cb = int'(cap_q.pop_front());
        else cb = -1;
        check_eq({tag, "_byte"}, 32'(cb), 32'(exp_byte[got]));
        got++;
        if (idx >= 0) rq_pos[idx]++;
        apply_reqs();
      end
    end
    check_eq({tag, "_ack_count"}, 32'(got), 32'(n_exp));
    repeat (3) @(negedge clk);
    check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_eq({tag, "_grant_end"}, 32'(grant), 32'd0);
  endtask

  task automatic wait_ack(input string tag, output logic [NR-1:0] a);
    int n;
    a = '0;
    n = 0;
    while (a == '0 && n < 3000) begin
      @(negedge clk);
      a = ack;
      n++;
    end
    check_eq({tag, "_ack_seen"}, 32'(a != '0), 32'd1);
  endtask

  task automatic gen_random();
    int nf;
    int len;
    bit any;
    clear_reqs();
    any = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if ($urandom_range(3, 0) != 0) begin
        any = 1'b1;
        nf = $urandom_range(3, 1);
        for (int f = 0; f < nf; f++) begin
          len = $urandom_range(3, 1);
          for (int b = 0; b < len; b++) add_byte(i, 8'($urandom_range(255, 0)), b == len - 1);
        end
      end
    end
    if (!any) add_byte(0, 8'($urandom_range(255, 0)), 1'b1);
  endtask

  initial begin : main
    logic [NR-1:0] a;
    logic [NR-1:0] ack_seen;
    int n;
    int cb;
    rst = 1'b1;
    req = '0;
    req_data = '0;
    req_last = '0;

    // reset state
    do_reset();
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_newd", 32'(tx_newd), 32'd0);
    check_eq("rst_data", 32'(tx_data), 32'h00);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);

    // single byte, latency and pulse shape
    @(negedge clk);
    req = 4'b0001;
    req_data = 32'h0000_00A5;
    req_last = 4'b0001;
    @(negedge clk);
    check_eq("t1_grant", 32'(grant), 32'h1);
    check_eq("t1_newd", 32'(tx_newd), 32'd1);
    check_eq("t1_data", 32'(tx_data), 32'hA5);
    check_eq("t1_busy", 32'(busy), 32'd1);
    wait_ack("t1", a);
    check_eq("t1_ack", 32'(a), 32'h1);
    req = '0;
    if (cap_q.size() > 0) cb = int'(cap_q.pop_front());
    else cb = -1;
    check_eq("t1_byte", 32'(cb), 32'hA5);
    @(negedge clk);
    check_eq("t1_ack_pulse", 32'(ack), 32'd0);
    check_eq("t1_busy_idle", 32'(busy), 32'd0);
    check_eq("t1_grant_idle", 32'(grant), 32'd0);

    // simultaneous requests 1 and 3
    do_reset();
    clear_reqs();
    add_byte(1, 8'h11, 1'b1);
    add_byte(3, 8'h33, 1'b1);
    run_scenario("t2");

    // frame lock: req0 three-byte frame while req2 waits
    do_reset();
    clear_reqs();
    add_byte(0, 8'h01, 1'b0);
    add_byte(0, 8'h02, 1'b0);
    add_byte(0, 8'h03, 1'b1);
    add_byte(2, 8'h22, 1'b1);
    run_scenario("t3");

    // fairness: all requesters held, single-byte frames
    do_reset();
    clear_reqs();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NR; i++) add_byte(i, 8'(16 * r + i + 8'h40), 1'b1);
    end
    run_scenario("t4");

    // lost done: timeout sets err, next request still served
    do_reset();
    uart_en = 1'b0;
    @(negedge clk);
    req = 4'b0001;
    req_data = 32'h0000_003C;
    req_last = 4'b0001;
    @(negedge clk);
    check_eq("t5_grant", 32'(grant), 32'h1);
    ack_seen = '0;
    repeat (HOLD + TOUT - 1) begin
      @(negedge clk);
      ack_seen |= ack;
    end
    check_eq("t5_err_before", 32'(err), 32'd0);
    @(negedge clk);
    ack_seen |= ack;
    req = '0;
    check_eq("t5_err", 32'(err), 32'd1);
    check_eq("t5_no_ack", 32'(ack_seen), 32'd0);
    check_eq("t5_grant_cleared", 32'(grant), 32'd0);
    check_eq("t5_busy_cleared", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("t5_idle", 32'(grant), 32'd0);
    uart_en = 1'b1;
    cap_q.delete();
    req = 4'b0100;
    req_data = 32'h005A_0000;
    req_last = 4'b0100;
    wait_ack("t5b", a);
    check_eq("t5b_ack", 32'(a), 32'h4);
    req = '0;
    if (cap_q.size() > 0) cb = int'(cap_q.pop_front());
    else cb = -1;
    check_eq("t5b_byte", 32'(cb), 32'h5A);
    check_eq("t5b_err_sticky", 32'(err), 32'd1);

    // reset during WAIT; the late done must not ack
    repeat (160) @(negedge clk);
    done_min = 100;
    done_max = 100;
    req = 4'b0010;
    req_data = 32'h0000_7700;
    req_last = 4'b0010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((tx_newd || n < 2) && n < 500);
    repeat (10) @(negedge clk);
    check_eq("t6_busy_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t6_grant", 32'(grant), 32'd0);
    check_eq("t6_newd", 32'(tx_newd), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_err", 32'(err), 32'd0);
    ack_seen = '0;
    repeat (300) begin
      @(negedge clk);
      ack_seen |= ack;
    end
    check_eq("t6_no_ack", 32'(ack_seen), 32'd0);
    check_eq("t6_grant_idle", 32'(grant), 32'd0);
    done_min = 50;
    done_max = 150;

    // randomized frames against the reference order
    for (int s = 0; s < 3; s++) begin
      do_reset();
      gen_random();
      run_scenario($sformatf("rand%0d", s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
